// File: rtl/pcss_flit_pkg.sv
// pcss_flit_pkg: flit type codes and default flit geometry shared by the PCSS blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pcss_flit_pkg;

  localparam int FLIT_W  = 59;  // full flit width
  localparam int FTYPE_W = 3;   // flit type field width (flit MSBs)
  localparam int SPK_W   = 24;  // spike payload width (x,y,z)

  typedef enum logic [2:0] {
    FT_SPIKE    = 3'b000,
    FT_DATA     = 3'b001,
    FT_DATA_END = 3'b010,
    FT_WRITE    = 3'b110,
    FT_READ     = 3'b111
  } flit_type_e;

endpackage

// File: rtl/spk_out_pkg.sv
// spk_out_pkg: local types and defaults of the spike/config flit output stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spk_out_pkg;

  localparam int SPK_FIFO_AW = 4;   // spike FIFO depth is 2**SPK_FIFO_AW
  localparam int SPK_CREDIT  = 16;  // downstream slots available after reset

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND_SPK = 2'd1,
    ST_SEND_CFG = 2'd2
  } spk_state_e;

endpackage

// File: rtl/spk_out_if.sv
// spk_out_if: soma spike input, config response input, credit return and router flit output.
// Latency: n/a (wires only).
// Backpressure: soma sees spk_out_soma_busy; router side is credit based (credit_in).
// master = the spk_out block, slave = its environment (soma, config unit, router).
interface spk_out_if
  import pcss_flit_pkg::*;
#(
  parameter int FW  = FLIT_W,
  parameter int FTW = FTYPE_W,
  parameter int SW  = SPK_W
);
  logic                  soma_spk_vld;
  logic [SW-1:0]         soma_spk_data;
  logic                  spk_out_soma_busy;
  logic [FW-FTW-SW-1:0]  cfg_dst;
  logic                  config_spk_out_vld;
  logic [FW-1:0]         config_spk_out_data;
  logic                  spk_out_config_credit;
  logic [FW-1:0]         flit_out;
  logic                  flit_out_wr;
  logic                  credit_in;

  modport master (
    input  soma_spk_vld, soma_spk_data, cfg_dst, config_spk_out_vld,
           config_spk_out_data, credit_in,
    output spk_out_soma_busy, spk_out_config_credit, flit_out, flit_out_wr
  );

  modport slave (
    output soma_spk_vld, soma_spk_data, cfg_dst, config_spk_out_vld,
           config_spk_out_data, credit_in,
    input  spk_out_soma_busy, spk_out_config_credit, flit_out, flit_out_wr
  );
endinterface

// File: rtl/data_fifo.sv
// data_fifo: generic synchronous FIFO, depth 2**ADDR_WIDTH, show-ahead read data.
// Latency: write visible on o_rdata the cycle after the push edge when empty.
// Backpressure: pushes while o_full and pops while o_empty are ignored.
// Ports: clk, rst_n (async active-low), i_wr/i_wdata push, i_rd pop,
//        o_rdata head entry, o_full, o_empty.
module data_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_rd,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_full,
  output logic                  o_empty
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic [ADDR_WIDTH:0]   r_cnt;
  logic                  w_wr;
  logic                  w_rd;

  assign w_wr    = i_wr & ~o_full;
  assign w_rd    = i_rd & ~o_empty;
  assign o_full  = (r_cnt == (ADDR_WIDTH+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_rdata = r_mem[r_rptr];

  // Storage carries no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

// File: rtl/spk_out.sv
// spk_out: merges soma spikes (queued) and config read responses into router flits.
// Latency: spike pushed at edge t into an idle block -> flit_out_wr in cycle t+2; 1 flit / 2 cycles.
// Backpressure: spike FIFO full -> spk_out_soma_busy, further spikes dropped; no send without a credit.
// Ports: clk, rst_n (async active-low); bus (spk_out_if.master): soma spike in + busy,
//        cfg_dst, config flit in + config credit pulse, flit_out/flit_out_wr, credit_in;
//        drop_cnt (only when SPK_OUT_DROP_CNT_EN is defined: saturating dropped-spike count).
module spk_out
  import pcss_flit_pkg::*;
  import spk_out_pkg::*;
#(
  parameter int FW     = FLIT_W,
  parameter int FTW    = FTYPE_W,
  parameter int SW     = SPK_W,
  parameter int B      = SPK_FIFO_AW,
  parameter int CREDIT = SPK_CREDIT
) (
  input  logic        clk,
  input  logic        rst_n,
  spk_out_if.master   bus
`ifdef SPK_OUT_DROP_CNT_EN
  ,
  output logic [15:0] drop_cnt
`endif
);
  localparam int CW = $clog2(CREDIT) + 1;

  spk_state_e     r_state;
  spk_state_e     w_state_nxt;
  logic           w_push;
  logic           w_pop;
  logic           w_fifo_full;
  logic           w_fifo_empty;
  logic [SW-1:0]  w_fifo_rdata;
  logic           w_credit_ok;
  logic           r_cfg_full;
  logic [FW-1:0]  r_cfg_dat;
  logic [CW-1:0]  r_credit;
  logic [FW-1:0]  r_flit_out;
  logic           r_flit_wr;
  logic           r_cfg_credit;

  assign w_push                    = bus.soma_spk_vld & ~w_fifo_full;
  assign bus.spk_out_soma_busy     = w_fifo_full;
  assign bus.flit_out              = r_flit_out;
  assign bus.flit_out_wr           = r_flit_wr;
  assign bus.spk_out_config_credit = r_cfg_credit;

  data_fifo #(
    .DATA_WIDTH (SW),
    .ADDR_WIDTH (B)
  ) u_spk_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_wr    (w_push),
    .i_wdata (bus.soma_spk_data),
    .i_rd    (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Config holding register: a new response is only taken when the slot is free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg_full <= 1'b0;
      r_cfg_dat  <= '0;
    end else if (r_state == ST_SEND_CFG) begin
      r_cfg_full <= 1'b0;
    end else if (bus.config_spk_out_vld && !r_cfg_full) begin
      r_cfg_full <= 1'b1;
      r_cfg_dat  <= bus.config_spk_out_data;
    end
  end

  // Credits are consumed when the flit leaves (flit_out_wr); a return in the
  // same cycle cancels out. Returns beyond CREDIT are absorbed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credit <= CW'(CREDIT);
    end else if (bus.credit_in && !r_flit_wr) begin
      if (r_credit != CW'(CREDIT)) r_credit <= r_credit + 1'b1;
    end else if (r_flit_wr && !bus.credit_in) begin
      r_credit <= r_credit - 1'b1;
    end
  end

  // The flit on flit_out_wr this cycle has not been charged yet, so the last
  // credit is treated as already spent while it is on the wire.
  assign w_credit_ok = (r_credit > CW'(1)) || ((r_credit == CW'(1)) && !r_flit_wr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Config responses win over queued spikes.
  always_comb begin
    w_state_nxt = ST_IDLE;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_cfg_full && w_credit_ok)         w_state_nxt = ST_SEND_CFG;
        else if (!w_fifo_empty && w_credit_ok) w_state_nxt = ST_SEND_SPK;
      end
      ST_SEND_SPK: w_pop = 1'b1;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flit_out   <= '0;
      r_flit_wr    <= 1'b0;
      r_cfg_credit <= 1'b0;
    end else begin
      r_flit_wr    <= 1'b0;
      r_cfg_credit <= 1'b0;
      if (r_state == ST_SEND_SPK) begin
        r_flit_out <= {FTW'(FT_SPIKE), bus.cfg_dst, w_fifo_rdata};
        r_flit_wr  <= 1'b1;
      end else if (r_state == ST_SEND_CFG) begin
        r_flit_out   <= r_cfg_dat;
        r_flit_wr    <= 1'b1;
        r_cfg_credit <= 1'b1;
      end
    end
  end

`ifdef SPK_OUT_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (bus.soma_spk_vld && w_fifo_full && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_spk_out.sv
// tb_spk_out: directed latency/priority/credit/reset scenarios plus a random
// mixed-traffic phase; a queue-based scoreboard checks every emitted flit.
`timescale 1ns/1ps
module tb_spk_out;
  import pcss_flit_pkg::*;

  localparam int FW     = FLIT_W;
  localparam int FTW    = FTYPE_W;
  localparam int SW     = SPK_W;
  localparam int DW     = FW - FTW - SW;
  localparam int DEPTH  = 16;
  localparam int CREDIT = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  spk_out_if #(.FW(FW), .FTW(FTW), .SW(SW)) u_if ();

`ifdef SPK_OUT_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  spk_out #(.FW(FW), .FTW(FTW), .SW(SW), .B(4), .CREDIT(CREDIT)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.master)
`ifdef SPK_OUT_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model (spec-level bookkeeping) ----------------
  logic [FW-1:0] spk_q[$];   // spike flits accepted, not yet emitted
  logic [FW-1:0] cfg_q[$];   // config flits accepted, not yet emitted
  int  occ      = 0;         // spikes held in the FIFO
  int  mcredit  = CREDIT;    // downstream credits
  int  drop_m   = 0;         // dropped spikes
  int  sent     = 0;         // flits seen on flit_out_wr
  bit  cfg_full_m = 1'b0;    // config slot occupied

  logic          cap_spk_vld, cap_cfg_vld, cap_credit_in, cap_wr;
  logic [SW-1:0] cap_spk_dat;
  logic [FW-1:0] cap_cfg_dat;

  // Inputs as seen by the DUT at each rising edge.
  always @(posedge clk) begin
    cap_spk_vld   <= u_if.soma_spk_vld;
    cap_spk_dat   <= u_if.soma_spk_data;
    cap_cfg_vld   <= u_if.config_spk_out_vld;
    cap_cfg_dat   <= u_if.config_spk_out_data;
    cap_credit_in <= u_if.credit_in;
    cap_wr        <= u_if.flit_out_wr;
  end

  // Monitor + model: evaluates what the last rising edge must have done.
  always @(negedge clk) begin
    if (!rst_n) begin
      spk_q.delete();
      cfg_q.delete();
      occ        = 0;
      mcredit    = CREDIT;
      drop_m     = 0;
      cfg_full_m = 1'b0;
    end else begin
      bit            was_full;
      bit            pop_spk;
      logic [FW-1:0] exp_flit;
      pop_spk = 1'b0;

      if (cap_credit_in && !cap_wr)      mcredit = (mcredit < CREDIT) ? mcredit + 1 : CREDIT;
      else if (cap_wr && !cap_credit_in) mcredit = mcredit - 1;

      check("cfg_credit_without_wr", u_if.spk_out_config_credit && !u_if.flit_out_wr, 1'b0);
      if (u_if.flit_out_wr) begin
        sent++;
        check("send_with_credit", mcredit > 0, 1'b1);
        if (u_if.spk_out_config_credit) begin
          check("cfg_flit_expected", cfg_q.size() != 0, 1'b1);
          if (cfg_q.size() != 0) begin
            exp_flit = cfg_q.pop_front();
            check("cfg_flit", u_if.flit_out, exp_flit);
          end
        end else begin
          pop_spk = 1'b1;
          check("spk_flit_expected", spk_q.size() != 0, 1'b1);
          if (spk_q.size() != 0) begin
            exp_flit = spk_q.pop_front();
            check("spk_flit", u_if.flit_out, exp_flit);
          end
        end
      end

      // Full-ness is judged before this edge's pop.
      if (cap_spk_vld) begin
        if (occ == DEPTH) begin
          if (drop_m < 65535) drop_m++;
        end else begin
          spk_q.push_back({3'b000, u_if.cfg_dst, cap_spk_dat});
          occ++;
        end
      end
      if (pop_spk && occ > 0) occ--;

      was_full = cfg_full_m;
      if (u_if.flit_out_wr && u_if.spk_out_config_credit) cfg_full_m = 1'b0;
      if (cap_cfg_vld && !was_full) begin
        cfg_q.push_back(cap_cfg_dat);
        cfg_full_m = 1'b1;
      end

      check("busy", u_if.spk_out_soma_busy, occ == DEPTH);
      check("credit_cnt", u_dut.r_credit, mcredit);
`ifdef SPK_OUT_DROP_CNT_EN
      check("drop_cnt", drop_cnt, drop_m);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    u_if.soma_spk_vld       = 1'b0;
    u_if.config_spk_out_vld = 1'b0;
    u_if.credit_in          = 1'b0;
  endtask

  task automatic give_credits(input int n);
    repeat (n) begin
      u_if.credit_in = 1'b1;
      step();
    end
    u_if.credit_in = 1'b0;
  endtask

  // Walk n cycles: no flit before the n-th, a flit (of the given kind) on it.
  task automatic expect_wr(input int n, input bit is_cfg, input string name);
    for (int k = 1; k <= n; k++) begin
      step();
      if (k < n) check({name, "_early"}, u_if.flit_out_wr, 1'b0);
      else begin
        check({name, "_wr"}, u_if.flit_out_wr, 1'b1);
        check({name, "_cfgcr"}, u_if.spk_out_config_credit, is_cfg);
      end
    end
  endtask

  // Return credits until everything queued has left and credit is full again.
  task automatic drain(input string name);
    int k;
    k = 0;
    idle_inputs();
    while ((spk_q.size() != 0 || cfg_q.size() != 0 || mcredit < CREDIT || u_if.flit_out_wr) && k < 500) begin
      u_if.credit_in = (mcredit < CREDIT);
      step();
      k++;
    end
    u_if.credit_in = 1'b0;
    step();
    check({name, "_drained"}, spk_q.size() + cfg_q.size(), 0);
    check({name, "_credit_full"}, u_dut.r_credit, CREDIT);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_flit_out"}, u_if.flit_out, '0);
    check({name, "_wr"}, u_if.flit_out_wr, 1'b0);
    check({name, "_cfgcr"}, u_if.spk_out_config_credit, 1'b0);
    check({name, "_busy"}, u_if.spk_out_soma_busy, 1'b0);
    check({name, "_credit"}, u_dut.r_credit, CREDIT);
`ifdef SPK_OUT_DROP_CNT_EN
    check({name, "_drop"}, drop_cnt, 16'd0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time=%0t exceeded limit=2000000", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- scenarios ----------------
  initial begin
    logic [FW-1:0] cfg_flit;
    int base;

    idle_inputs();
    u_if.cfg_dst             = 32'hA5A5_0001;
    u_if.soma_spk_data       = '0;
    u_if.config_spk_out_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    // Single spike: flit two cycles after the push edge, credit charged after.
    u_if.soma_spk_vld  = 1'b1;
    u_if.soma_spk_data = 24'h010203;
    step();
    u_if.soma_spk_vld  = 1'b0;
    expect_wr(2, 1'b0, "single");
    cfg_flit = {3'b000, 32'hA5A5_0001, 24'h010203};
    check("single_flit", u_if.flit_out, cfg_flit);
    step();
    check("single_credit", u_dut.r_credit, 15);
    check("single_hold", u_if.flit_out, cfg_flit);
    give_credits(1);

    // Config and spike in the same cycle: config first, spike two cycles later.
    cfg_flit = {3'b110, 56'h00DE_ADBE_EF12_34};
    u_if.config_spk_out_vld  = 1'b1;
    u_if.config_spk_out_data = cfg_flit;
    u_if.soma_spk_vld        = 1'b1;
    u_if.soma_spk_data       = 24'h0A0B0C;
    step();
    idle_inputs();
    expect_wr(2, 1'b1, "prio_cfg");
    check("prio_cfg_flit", u_if.flit_out, cfg_flit);
    expect_wr(2, 1'b0, "prio_spk");
    step();
    step();
    give_credits(2);

    // 17 spikes, no credit return: 16 leave, the 17th waits for one credit.
    base = sent;
    u_if.soma_spk_vld = 1'b1;
    for (int i = 0; i < 17; i++) begin
      u_if.soma_spk_data = 24'($urandom);
      step();
    end
    u_if.soma_spk_vld = 1'b0;
    repeat (40) step();
    check("stall_after_16", sent - base, 16);
    check("stall_credit", u_dut.r_credit, 0);
    give_credits(1);
    repeat (6) step();
    check("resume_17th", sent - base, 17);

    // Fill the FIFO with no credit: 16 accepted, busy, 17th dropped.
    u_if.soma_spk_vld = 1'b1;
    for (int i = 0; i < 17; i++) begin
      u_if.soma_spk_data = 24'($urandom);
      step();
    end
    check("fill_busy", u_if.spk_out_soma_busy, 1'b1);
    check("fill_no_send", sent - base, 17);
`ifdef SPK_OUT_DROP_CNT_EN
    check("fill_drop_one", drop_cnt, 16'd1);
`endif
    // Keep requesting while one credit lets a pop happen against a full FIFO.
    u_if.credit_in = 1'b1;
    step();
    u_if.credit_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      u_if.soma_spk_data = 24'($urandom);
      step();
    end
    check("full_pop_refill_busy", u_if.spk_out_soma_busy, 1'b1);
    drain("fill");

    // Credit saturation and return coinciding with a send.
    u_if.credit_in = 1'b1;
    step();
    u_if.credit_in = 1'b0;
    check("credit_sat", u_dut.r_credit, CREDIT);
    u_if.soma_spk_vld  = 1'b1;
    u_if.soma_spk_data = 24'h5A5A5A;
    step();
    u_if.soma_spk_vld  = 1'b0;
    step();
    step();
    check("coincide_wr", u_if.flit_out_wr, 1'b1);
    u_if.credit_in = 1'b1;
    step();
    u_if.credit_in = 1'b0;
    check("credit_coincide", u_dut.r_credit, CREDIT);
    step();

    // Reset mid-stream with spikes queued: everything cleared, nothing sent after.
    u_if.soma_spk_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      u_if.soma_spk_data = 24'($urandom);
      step();
    end
    u_if.soma_spk_vld = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) step();
    rst_n = 1'b1;
    base = sent;
    repeat (20) step();
    check("no_wr_after_reset", sent - base, 0);

    // Random mixed traffic; credit returns slower than sends so the FIFO fills.
    for (int c = 0; c < 3000; c++) begin
      u_if.soma_spk_vld        = ($urandom_range(0, 99) < 45);
      u_if.soma_spk_data       = 24'($urandom);
      u_if.config_spk_out_vld  = ($urandom_range(0, 99) < 8);
      u_if.config_spk_out_data = {($urandom_range(0, 1) != 0) ? 3'b110 : 3'b111,
                                  56'({$urandom, $urandom})};
      u_if.credit_in           = (mcredit < CREDIT) && ($urandom_range(0, 99) < 40);
      step();
    end
    drain("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
